muldiv_stall_ctrl: RTL

//  Sequencer for the multi-cycle mul/div unit in the EX stage. Detects a mul/div op in EX,

---
 rtl/muldiv_stall_ctrl.sv | 112 +++++++++++
 1 files changed

// File: rtl/muldiv_stall_ctrl.sv
// Mul/div sequencer for the EX stage: launches the multi-cycle unit, holds F/D/E for
// MD_LATENCY cycles, then selects the unit result for one cycle. Merges hazard stall/flush.
module muldiv_stall_ctrl #(
    parameter int unsigned MD_LATENCY = 32,
    parameter int unsigned CNT_W      = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mdop_E,
    input  logic        lwstall_in,
    input  logic        Eval_branch,
    output logic        StallF,
    output logic        StallD,
    output logic        StallE,
    output logic        FlushD,
    output logic        FlushE,
    output logic        FlushM,
    output logic        unit_start,
    output logic        md_result_sel,
    output logic        md_busy,
    output logic [31:0] md_stall_cnt
);

    localparam int unsigned STAT_W = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic [STAT_W-1:0]   r_stall_cnt;
    logic                w_start;
    logic                w_md_stall;

    // State, latency counter and saturating stall statistics
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_md_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + STAT_W'(1);
            end
        end
    end

    // Next state and all pipeline controls; everything is forced low while in reset
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_start       = 1'b0;
        w_md_stall    = 1'b0;
        StallF        = 1'b0;
        StallD        = 1'b0;
        StallE        = 1'b0;
        FlushD        = 1'b0;
        FlushE        = 1'b0;
        FlushM        = 1'b0;
        unit_start    = 1'b0;
        md_result_sel = 1'b0;
        md_busy       = 1'b0;
        md_stall_cnt  = '0;

        w_start = (r_state == S_IDLE) && mdop_E && !Eval_branch && !rst;

        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_cnt_nxt   = CNT_W'(1);
                    w_state_nxt = (MD_LATENCY == 1) ? S_DONE : S_BUSY;
                end
            end
            S_BUSY: begin
                if (r_cnt == CNT_W'(MD_LATENCY - 1)) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            // The op in EX during DONE is the one that just finished, so mdop_E is ignored
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (!rst) begin
            w_md_stall    = w_start || (r_state == S_BUSY);
            StallF        = lwstall_in || w_md_stall;
            StallD        = lwstall_in || w_md_stall;
            StallE        = w_md_stall;
            FlushM        = w_md_stall;
            FlushE        = (lwstall_in && !w_md_stall) || Eval_branch;
            FlushD        = Eval_branch;
            unit_start    = w_start;
            md_result_sel = (r_state == S_DONE);
            md_busy       = (r_state != S_IDLE);
            md_stall_cnt  = r_stall_cnt;
        end
    end

endmodule
